seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumes the 32-bit display_result bus produced by the single-cycle RISC-V top and
//  shows it as 8 hex digits on a time-multiplexed, common-anode 7-segment display.
//  Snapshots the value once per scan frame so the display never tears, and blanks
//  leading zeros. Sits between the CPU top and the board display pins.
// PARAMETERS
//  REFRESH_DIV    100000  clk cycles each digit is lit; must be >= 2 (sims use 4)
//  NUM_DIGITS     8       digits scanned; fixed at 8 for a 32-bit value
//  BLANK_LEADING  1       1 = blank leading-zero digits; 0 = show all digits
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  value       in   32  word to display (CPU display_result)
//  freeze      in   1   1 = hold the current snapshot and ignore value
//  an          out  8   digit enables, active-low, an[i] = nibble i (LSN = an[0])
//  seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1   decimal point, active-low; held 1 (off)
//  frame_tick  out  1   1-cycle pulse on the cycle the snapshot register is (re)loaded
// BEHAVIOUR
//  Reset (async): div_cnt=0, digit_idx=0, snapshot=0, an=8'hFF, seg=7'h7F, dp=1,
//   frame_tick=0. Everything below happens only after reset deasserts.
//  Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. Terminal count (TC) is
//   div_cnt==REFRESH_DIV-1.
//  Scan: on TC, digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1.
//  Snapshot: on TC with digit_idx==NUM_DIGITS-1 (the frame wrap):
//   - if freeze==0, snapshot <= value.
//   - frame_tick is 1 for that cycle whenever freeze==0; frame_tick stays 0 when freeze==1.
//   - snapshot is never loaded at any other time. A change to value mid-frame appears
//     only after the next wrap.
//  First frame after reset: shows snapshot=0. The first load happens at the end of
//   frame 0, that is NUM_DIGITS*REFRESH_DIV cycles after reset release.
//  Output: an, seg and dp are registered and lag digit_idx/snapshot by 1 cycle.
//   - an = ~(8'b1 << digit_idx), except blanked digits, where an = 8'hFF.
//   - seg = hex_to_seg7(snapshot[4*digit_idx +: 4]).
//  Blanking: digit i (i>0) is blanked when BLANK_LEADING=1 and snapshot[31:4*i]==0.
//   Digit 0 is never blanked, so value 0 shows a single '0'.
//  Only one an bit is ever low. No cycle has two digits enabled at once.
//  Reset mid-frame: all state returns to reset values at once, and the display is dark
//   the following cycle.
//  freeze toggling exactly at a wrap: freeze is sampled on the wrap cycle only.
// STRUCTURE
//  seg7_pkg:
//   - SEG_HEX[0:15] segment patterns, e.g. 0=7'h40, 1=7'h79, 5=7'h12, A=7'h08, F=7'h0E.
//   - SEG_OFF=7'h7F, AN_OFF=8'hFF.
//  Sub-module hex_to_seg7: combinational nibble-to-segment lookup, 4 in / 7 out.
//  Top level holds the divider, digit counter, snapshot register, blanking compare and
//   output registers.
// TESTING (REFRESH_DIV=4, BLANK_LEADING=1 unless stated)
//  1. Assert reset for 3 cycles -> an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, both during
//     reset and the cycle after.
//  2. value=32'h0000_00A5, run 2 frames -> frame 2 shows:
//     - an=8'hFE with seg=7'h12 ('5').
//     - an=8'hFD with seg=7'h08 ('A').
//     - digits 2..7 with an=8'hFF.
//     - each digit held exactly 4 cycles.
//  3. value changes to 32'hFFFF_FFFF mid-frame -> rest of the frame is unchanged;
//     frame_tick pulses once at the wrap; next frame shows all 8 digits at seg=7'h0E.
//  4. freeze=1 across 3 wraps while value changes -> snapshot and display unchanged,
//     frame_tick stays 0; after freeze=0 the next wrap loads the new value.
//  5. value=0 -> only an[0] is ever low, seg=7'h40; with BLANK_LEADING=0, all 8 digits
//     show '0'.
//  6. Assert reset during digit 5 of a frame -> outputs go dark next cycle; the scan
//     restarts at digit 0 with snapshot=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
//  SEG_HEX : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//  SEG_OFF : all segments dark
//  AN_OFF  : all digit enables inactive
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment lookup.
//  nibble_i : hex digit 0..F
//  seg_o    : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// The displayed word is snapshotted once per scan frame so a digit sequence never
// mixes two values, and leading zeros can be blanked.
//  clk_i        : system clock
//  rst_i        : asynchronous active-high reset
//  value_i      : word to display
//  freeze_i     : 1 = keep the current snapshot at the frame wrap
//  an_o         : active-low digit enables, an_o[i] = nibble i
//  seg_o        : active-low segments {g,f,e,d,c,b,a}
//  dp_o         : active-low decimal point, always off
//  frame_tick_o : pulses on the cycle the snapshot is reloaded
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  input  logic        freeze_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_tick_o
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
  localparam logic [2:0] LastDigit = 3'(NUM_DIGITS - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      digit_idx_q, digit_idx_d;
  logic [31:0]     snapshot_q, snapshot_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic        tc, wrap, load, blank;
  logic [3:0]  nibble;
  logic [31:0] upper;
  logic [6:0]  seg_dec;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    tc   = (div_cnt_q == DivLast);
    wrap = tc && (digit_idx_q == LastDigit);
    // freeze only matters on the wrap cycle; that is the only load opportunity
    load = wrap && !freeze_i;

    div_cnt_d   = tc ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (tc) begin
      digit_idx_d = (digit_idx_q == LastDigit) ? 3'd0 : digit_idx_q + 3'd1;
    end
    snapshot_d = load ? value_i : snapshot_q;

    nibble = snapshot_q[{digit_idx_q, 2'b00} +: 4];
    // A digit is leading-zero when it and every nibble above it are zero
    upper  = snapshot_q >> {digit_idx_q, 2'b00};
    blank  = (BLANK_LEADING != 0) && (digit_idx_q != 3'd0) && (upper == 32'd0);

    an_d  = blank ? AN_OFF : ~(8'b1 << digit_idx_q);
    seg_d = seg_dec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 3'd0;
      snapshot_q  <= 32'd0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      snapshot_q  <= snapshot_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = 1'b1;
  assign frame_tick_o = load;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  typedef logic [7:0] an_tab_t [8];
  typedef logic [6:0] seg_tab_t [8];

  typedef struct {
    string      name;
    logic [7:0] an;
    logic [6:0] seg;
    logic       tick;
    logic [7:0] an_nb;
    logic [6:0] seg_nb;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] value_i;
  logic        freeze_i;
  logic [7:0]  an_o, an_nb;
  logic [6:0]  seg_o, seg_nb;
  logic        dp_o, dp_nb;
  logic        tick_o, tick_nb;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        q[$];

  // Hand-computed per-digit expectations (index = digit number)
  an_tab_t  AN_ALL  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  an_tab_t  AN_D0   = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  an_tab_t  AN_A5   = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  an_tab_t  AN_3C   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
  seg_tab_t SEG_Z   = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  seg_tab_t SEG_A5  = '{7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  seg_tab_t SEG_F   = '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
  seg_tab_t SEG_3C  = '{7'h40, 7'h40, 7'h46, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40};

  seg7_scan_driver #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_LEADING(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .value_i      (value_i),
    .freeze_i     (freeze_i),
    .an_o         (an_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .frame_tick_o (tick_o)
  );

  // Second instance without blanking, always fed zero
  seg7_scan_driver #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_LEADING(0)) dut_nb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .value_i      (32'd0),
    .freeze_i     (1'b0),
    .an_o         (an_nb),
    .seg_o        (seg_nb),
    .dp_o         (dp_nb),
    .frame_tick_o (tick_nb)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock period, compared mid-period
  always @(negedge clk_i) begin
    exp_t e;
    chk("an_onehot", 32'($countones(~an_o) <= 1), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.name, ".an"},     32'(an_o),   32'(e.an));
      chk({e.name, ".seg"},    32'(seg_o),  32'(e.seg));
      chk({e.name, ".dp"},     32'(dp_o),   32'd1);
      chk({e.name, ".tick"},   32'(tick_o), 32'(e.tick));
      chk({e.name, ".an_nb"},  32'(an_nb),  32'(e.an_nb));
      chk({e.name, ".seg_nb"}, 32'(seg_nb), 32'(e.seg_nb));
    end
  end

  task automatic push(input string nm, input logic [7:0] an, input logic [6:0] seg,
                      input logic tick, input logic [7:0] an_n, input logic [6:0] seg_n);
    exp_t e;
    e.name = nm; e.an = an; e.seg = seg; e.tick = tick; e.an_nb = an_n; e.seg_nb = seg_n;
    q.push_back(e);
  endtask

  task automatic step_dark(input string nm);
    @(posedge clk_i);
    #1;
    push(nm, 8'hFF, 7'h7F, 1'b0, 8'hFF, 7'h7F);
  endtask

  // One displayed frame: 8 digits x 4 cycles; the wrap cycle is the 31st (j=30).
  task automatic run_frame(input string nm, input an_tab_t an_t, input seg_tab_t seg_t,
                           input logic tick, input int ncyc, input int chg_at,
                           input logic [31:0] chg_val, input int frz_at, input logic frz_val);
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk_i);
      #1;
      push(nm, an_t[j/4], seg_t[j/4], (j == 30) ? tick : 1'b0, AN_ALL[j/4], 7'h40);
      if (j == chg_at) value_i = chg_val;
      if (j == frz_at) freeze_i = frz_val;
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    value_i  = 32'h0000_00A5;
    freeze_i = 1'b0;
    step_dark("reset");
    step_dark("reset");
    step_dark("reset_after");
    rst_i = 1'b0;

    run_frame("f0_zero",   AN_D0, SEG_Z,  1'b1, 32, -1, 32'd0, -1, 1'b0);
    run_frame("f1_a5",     AN_A5, SEG_A5, 1'b1, 32, -1, 32'd0, -1, 1'b0);
    run_frame("f2_a5_chg", AN_A5, SEG_A5, 1'b1, 32, 10, 32'hFFFF_FFFF, -1, 1'b0);
    run_frame("f3_ff_frz", AN_ALL, SEG_F, 1'b0, 32, 5, 32'h1234_5678, 0, 1'b1);
    run_frame("f4_frz",    AN_ALL, SEG_F, 1'b0, 32, 5, 32'h0000_ABCD, -1, 1'b0);
    run_frame("f5_frz",    AN_ALL, SEG_F, 1'b0, 32, 29, 32'h0000_0000, -1, 1'b0);
    run_frame("f6_unfrz",  AN_ALL, SEG_F, 1'b1, 32, -1, 32'd0, 0, 1'b0);
    run_frame("f7_zero",   AN_D0, SEG_Z,  1'b1, 32, 3, 32'h0030_0C00, -1, 1'b0);
    // Stop inside digit 5 and reset mid-frame
    run_frame("f8_inner0", AN_3C, SEG_3C, 1'b0, 21, -1, 32'd0, -1, 1'b0);
    step_dark("rst_mid");
    rst_i = 1'b1;
    step_dark("rst_mid");
    step_dark("rst_mid_after");
    rst_i = 1'b0;
    run_frame("r0_zero",   AN_D0, SEG_Z,  1'b1, 32, -1, 32'd0, -1, 1'b0);
    run_frame("r1_inner0", AN_3C, SEG_3C, 1'b1, 32, -1, 32'd0, -1, 1'b0);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
